// File: rtl/bali_loader_pkg.sv
// Shared definitions for the program loader.
//   loader_state_t : frame-parser state encoding
//   LOADER_MAGIC   : default frame start byte
package bali_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hBA;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader.
// Parses frames of the form MAGIC, LEN_HI, LEN_LO, LEN payload bytes, CHK
// (CHK = XOR of the payload) and writes the payload to program memory
// starting at address 0. The CPU is held in reset until a frame verifies.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_data    stream byte            in_valid  byte valid
//   in_ready   loader can take a byte this cycle
//   mem_we     one-cycle write strobe per payload byte
//   mem_addr   write address          mem_wdata write data
//   cpu_rst    CPU reset, high unless a verified image is running
//   done       last frame verified, CPU running
//   err        last frame rejected (length or checksum)
module prog_loader
    import bali_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] MAGIC      = LOADER_MAGIC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    // idx carries one extra bit so a full 2^ADDR_WIDTH image can be counted.
    localparam int          IW      = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_WIDTH;

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            acc_q, acc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;

    logic        accept;
    logic [15:0] len_full;

    assign accept   = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                // Only MAGIC starts a frame; anything else is dropped.
                if (accept && in_data == MAGIC) begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    idx_d = '0;
                    acc_d = 8'h00;
                    if (32'(len_full) > MAX_LEN) begin
                        state_d = ST_ERROR;
                    end else if (len_full == 16'h0000) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data;
                    acc_d   = acc_q ^ in_data;
                    idx_d   = idx_q + 1'b1;
                    if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? ST_RELEASE : ST_ERROR;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Status outputs are decodes of the registered state, so they change
    // exactly one cycle after the byte that caused the transition.
    assign in_ready  = (state_q != ST_RELEASE);
    assign cpu_rst   = (state_q != ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign err       = (state_q == ST_ERROR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan
// followed by randomized frames, checked against expectations derived from
// the frame contents.
module tb_prog_loader;

    localparam int         AW    = 12;
    localparam logic [7:0] MAGIC = 8'hBA;
    localparam int         MAXL  = 1 << AW;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    prog_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit e_rst, input bit e_done, input bit e_err);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(e_rst));
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_err"}, 32'(err), 32'(e_err));
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gap_no_write", 32'(mem_we), 32'd0);
    endtask

    function automatic logic [7:0] rand_non_magic();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == MAGIC) b = 8'h00;
        return b;
    endfunction

    // Transfer one byte (after 0..max_gap idle cycles) and check the write
    // port in the cycle following the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_we, input int exp_addr, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) idle_cycle();
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(b));
        end
        $display("byte %02h we=%0b addr=%0d wdata=%02h rst=%0b done=%0b err=%0b",
                 b, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
    endtask

    // Send a whole frame. Expected behaviour comes from the frame rules:
    // over-long LEN is rejected right after LEN_LO, otherwise payload byte k
    // is written at address k and the checksum decides release vs error.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] payload[$],
                              input bit corrupt, input int max_gap);
        logic [7:0] x;
        logic [7:0] chk;
        x = 8'h00;
        foreach (payload[k]) x ^= payload[k];
        chk = corrupt ? (x ^ (8'h01 << $urandom_range(7, 0))) : x;
        send_byte(MAGIC, 1'b0, 0, max_gap);
        check_status("after_magic", 1'b1, 1'b0, 1'b0);
        send_byte(len[15:8], 1'b0, 0, max_gap);
        send_byte(len[7:0], 1'b0, 0, max_gap);
        if (int'(len) > MAXL) begin
            check_status("len_reject", 1'b1, 1'b0, 1'b1);
            foreach (payload[k]) send_byte(payload[k], 1'b0, 0, max_gap);
            check_status("reject_hold", 1'b1, 1'b0, 1'b1);
            $display("frame len=%0d rejected err=%0b", len, err);
        end else begin
            foreach (payload[k]) send_byte(payload[k], 1'b1, k, max_gap);
            send_byte(chk, 1'b0, 0, max_gap);
            if (!corrupt) begin
                check("release_in_ready", 32'(in_ready), 32'd0);
                check_status("release", 1'b1, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                check_status("run", 1'b0, 1'b1, 1'b0);
            end else begin
                check_status("chk_mismatch", 1'b1, 1'b0, 1'b1);
            end
            $display("frame len=%0d corrupt=%0b done=%0b err=%0b", len, corrupt, done, err);
        end
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [15:0] len;
        int kind;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check_status("reset", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;

        // Garbage in IDLE, then an empty frame.
        send_byte(8'h00, 1'b0, 0, 0);
        send_byte(8'hFF, 1'b0, 0, 0);
        send_byte(8'h12, 1'b0, 0, 0);
        check_status("garbage_idle", 1'b1, 1'b0, 1'b0);
        pl = {};
        send_frame(16'd0, pl, 1'b0, 0);

        // Basic two-byte frame, back-to-back writes.
        pl = '{8'hCA, 8'hFE};
        send_frame(16'd2, pl, 1'b0, 0);

        // Same frame with wrong checksum.
        send_frame(16'd2, pl, 1'b1, 0);

        // LEN 4097 rejected; next MAGIC clears err.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h1001, pl, 1'b0, 0);

        // Second load over a running image.
        pl = '{8'hCA, 8'hFE};
        send_frame(16'd2, pl, 1'b0, 0);
        pl = '{8'hAB};
        send_frame(16'd1, pl, 1'b0, 0);

        // Reset mid-frame after the first payload byte.
        send_byte(MAGIC, 1'b0, 0, 0);
        send_byte(8'h00, 1'b0, 0, 0);
        send_byte(8'h02, 1'b0, 0, 0);
        send_byte(8'hCA, 1'b1, 0, 0);
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_status("arst", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pl = '{8'h5A, 8'hC3};
        send_frame(16'd2, pl, 1'b0, 2);

        // Largest accepted image: top write lands at 2^AW-1.
        pl = {};
        for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
        send_frame(16'(MAXL), pl, 1'b0, 0);

        // Randomized frames with input gaps and stray bytes between frames.
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(9, 0));
            if ($urandom_range(1, 0) == 1) send_byte(rand_non_magic(), 1'b0, 0, 1);
            pl = {};
            if (kind == 0) begin
                len = 16'(MAXL + 1 + int'($urandom_range(60000, 0)));
                for (int i = 0; i < int'($urandom_range(3, 0)); i++) pl.push_back(rand_non_magic());
                send_frame(len, pl, 1'b0, 2);
            end else begin
                len = 16'($urandom_range(24, 0));
                for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
                send_frame(len, pl, kind == 1, 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that sits between a host link (UART/debug bridge) and the CPU's program memory. It parses a framed bytecode image, writes each payload byte to sequential program-memory addresses starting at 0, and holds the CPU in reset for the whole load. It releases the CPU only after a valid checksum. This is the write side of the program/state interface the CPU benches read back from memory and stack after a run.

## Interface
- `ADDR_WIDTH`, default 12: program-memory address width; maximum image size is 2^ADDR_WIDTH bytes.
- `MAGIC`, default 8'hBA: frame start byte.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_data`  in  8  incoming stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle; transfer occurs when `in_valid && in_ready` at a rising edge.
- `mem_we`  out  1  program-memory write strobe, one cycle per payload byte.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  8  write data.
- `cpu_rst`  out  1  active-high reset to the CPU; high while the CPU is not running a verified image.
- `done`  out  1  last frame loaded and verified; CPU running.
- `err`  out  1  last frame rejected (length or checksum).

## Operation
- Frame format: `MAGIC`, LEN_HI, LEN_LO, LEN payload bytes, CHK. CHK is the XOR of all payload bytes; for LEN=0 it is 8'h00.
- States:
  - IDLE: discard every byte except `MAGIC`; on `MAGIC` go to LEN_HI.
  - LEN_HI: latch the upper length byte, go to LEN_LO.
  - LEN_LO: latch the lower length byte. If LEN > 2^ADDR_WIDTH, go to ERROR. If LEN = 0, go to CHECK. Otherwise go to DATA with idx = 0 and the XOR accumulator = 0.
  - DATA: for each byte, issue a write at address idx, XOR it into the accumulator, and increment idx. After byte LEN-1, go to CHECK.
  - CHECK: compare the received byte with the accumulator. On a match go to RELEASE; on a mismatch go to ERROR.
  - RELEASE: a single cycle with `in_ready` = 0, `cpu_rst` falling, then go to RUN.
  - RUN: `done` = 1 and `cpu_rst` = 0. A `MAGIC` byte starts a new load: `cpu_rst` goes to 1, `done` to 0, and the state to LEN_HI. Any other byte is discarded.
  - ERROR: `err` = 1 and `cpu_rst` = 1. A `MAGIC` byte clears `err` and goes to LEN_HI. Any other byte is discarded.
- On entry to LEN_HI from any state, `cpu_rst` = 1, `done` = 0 and `err` = 0.
- A partially written image is never executed; memory contents past the last good write are undefined.
- idx is ADDR_WIDTH+1 bits wide, so LEN = 2^ADDR_WIDTH is accepted. The top write lands at address 2^ADDR_WIDTH-1 and there is no wrap-around.
- No timeout. A stalled frame waits indefinitely with the CPU held in reset.

## Timing
- Reset values: `in_ready` 1, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_rst` 1, `done` 0, `err` 0, state IDLE.
- Asynchronous assertion of `rst` at any point, including mid-frame, returns to these values immediately.
- `in_ready` is 1 in every state except RELEASE.
- Write latency: a payload byte accepted at edge t drives `mem_we`, `mem_addr` and `mem_wdata` registered during the cycle after t, for exactly one cycle.
- Back-to-back bytes produce back-to-back writes.
- CHK accepted at edge t:
  - Match: RELEASE in the cycle after t; RUN, `done` = 1 and `cpu_rst` = 0 from the cycle after that.
  - Mismatch: `err` = 1 in the cycle after t.
- Length rejection: `err` = 1 in the cycle after LEN_LO is accepted.
- `MAGIC` accepted at edge t in RUN: `cpu_rst` = 1 and `done` = 0 in the cycle after t.
- `in_valid` low: no state change and no write.

## Structure
- Shared package `bali_loader_pkg`: the state enum `loader_state_t` and the default magic constant `LOADER_MAGIC` = 8'hBA.
- Single flat module: one FSM, the length register, the idx counter, the XOR accumulator and the registered write port. No sub-module is needed.

## Test plan
- Frame BA 00 02 CA FE 34 -> writes (0,CA) then (1,FE) on consecutive cycles; `done` = 1 and `cpu_rst` = 0 two cycles after CHK; `err` = 0.
- Same frame with CHK 35 -> both writes still occur; `err` = 1; `cpu_rst` stays 1; `done` = 0.
- Frame BA 10 01 … with ADDR_WIDTH = 12 (LEN 4097) -> `err` = 1 after LEN_LO; no writes; next `MAGIC` clears `err`.
- Garbage 00 FF 12 followed by BA 00 00 00 -> garbage ignored; zero writes; `done` = 1.
- Valid load followed by a second frame BA 00 01 AB AB -> `cpu_rst` = 1 the cycle after the second BA; write (0,AB); `done` again.
- `rst` pulsed low after 1 of 2 payload bytes -> all outputs at reset values at once; a subsequent full frame loads correctly; `in_valid` gaps inside any frame cause no extra writes.
